// File: rtl/reg_writeback_unit.sv
// Writeback initiator for the 32 x 64-bit integer register file: queues load/ALU results and issues isolated one-cycle write strobes.
// Optional combinational bypass lookup is built when WB_BYPASS_EN is defined.
module reg_writeback_unit #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       ld_valid,
  output logic                       ld_ready,
  input  logic [ADDR_W-1:0]          ld_rd,
  input  logic [DATA_W-1:0]          ld_data,
  input  logic                       alu_valid,
  output logic                       alu_ready,
  input  logic [ADDR_W-1:0]          alu_rd,
  input  logic [DATA_W-1:0]          alu_data,
  output logic                       Wen,
  output logic [ADDR_W-1:0]          Rd_addr,
  output logic [DATA_W-1:0]          write_data,
  output logic [31:0]                busy_mask,
  output logic [$clog2(DEPTH):0]     fifo_count,
`ifdef WB_BYPASS_EN
  input  logic [ADDR_W-1:0]          lookup_addr,
  output logic                       lookup_hit,
  output logic [DATA_W-1:0]          lookup_data,
`endif
  output logic                       state_dbg
);

  // Handshake: a source transfers on a rising edge where its valid and ready are both high;
  // ready depends only on the pre-edge occupancy (and, for the ALU, on a pending load slot).

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {IDLE = 1'b0, WRITE = 1'b1} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   rd_q   [DEPTH];
  logic [DATA_W-1:0]   data_q [DEPTH];
  logic [PTR_W-1:0]    wr_ptr, rd_ptr, alu_slot;
  logic                ld_slot, ld_push, alu_push, pop;
  logic [CNT_W-1:0]    push_cnt;

  assign state_dbg = state_q;

  // Credit logic: x0 destinations complete the handshake but take no slot.
  always_comb begin
    ld_slot   = ld_valid && (ld_rd != '0);
    ld_ready  = fifo_count < CNT_W'(DEPTH);
    alu_ready = (fifo_count + CNT_W'(ld_slot)) < CNT_W'(DEPTH);
    ld_push   = ld_slot && ld_ready;
    alu_push  = alu_valid && alu_ready && (alu_rd != '0);
    alu_slot  = wr_ptr + PTR_W'(ld_push);
    push_cnt  = CNT_W'(ld_push) + CNT_W'(alu_push);
  end

  always_ff @(posedge clk) begin
    if (ld_push) begin
      rd_q[wr_ptr]   <= ld_rd;
      data_q[wr_ptr] <= ld_data;
    end
    if (alu_push) begin
      rd_q[alu_slot]   <= alu_rd;
      data_q[alu_slot] <= alu_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      wr_ptr     <= wr_ptr + PTR_W'(push_cnt);
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      fifo_count <= fifo_count + push_cnt - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (fifo_count != '0) state_d = WRITE;
      WRITE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Pop only from IDLE so every strobe is followed by at least one low cycle.
  always_comb begin
    pop = (state_q == IDLE) && (fifo_count != '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Wen        <= 1'b0;
      Rd_addr    <= '0;
      write_data <= '0;
    end else begin
      Wen <= pop;
      if (pop) begin
        Rd_addr    <= rd_q[rd_ptr];
        write_data <= data_q[rd_ptr];
      end
    end
  end

  always_comb begin
    logic [PTR_W-1:0] idx;
    idx       = '0;
    busy_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr + PTR_W'(i);
      if (CNT_W'(i) < fifo_count) busy_mask[rd_q[idx]] = 1'b1;
    end
    if (state_q == WRITE) busy_mask[Rd_addr] = 1'b1;
    busy_mask[0] = 1'b0;
  end

`ifdef WB_BYPASS_EN
  // Scan oldest to newest so the youngest match wins; the in-flight entry is older than any queued one.
  always_comb begin
    logic [PTR_W-1:0] idx;
    idx         = '0;
    lookup_hit  = 1'b0;
    lookup_data = '0;
    if ((state_q == WRITE) && (Rd_addr == lookup_addr)) begin
      lookup_hit  = 1'b1;
      lookup_data = write_data;
    end
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr + PTR_W'(i);
      if ((CNT_W'(i) < fifo_count) && (rd_q[idx] == lookup_addr)) begin
        lookup_hit  = 1'b1;
        lookup_data = data_q[idx];
      end
    end
    if (lookup_addr == '0) begin
      lookup_hit  = 1'b0;
      lookup_data = '0;
    end
  end
`endif

endmodule

// File: tb/tb_reg_writeback_unit.sv
// Self-checking bench for reg_writeback_unit: a reference occupancy/state model plus an expected-write queue.
module tb_reg_writeback_unit;

  localparam int DATA_W = 64;
  localparam int ADDR_W = 5;
  localparam int DEPTH  = 4;
  localparam int E_W    = ADDR_W + DATA_W;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              ld_valid = 1'b0, alu_valid = 1'b0;
  logic              ld_ready, alu_ready;
  logic [ADDR_W-1:0] ld_rd = '0, alu_rd = '0;
  logic [DATA_W-1:0] ld_data = '0, alu_data = '0;
  logic              Wen;
  logic [ADDR_W-1:0] Rd_addr;
  logic [DATA_W-1:0] write_data;
  logic [31:0]       busy_mask;
  logic [$clog2(DEPTH):0] fifo_count;
  logic              state_dbg;
`ifdef WB_BYPASS_EN
  logic [ADDR_W-1:0] lookup_addr = '0;
  logic              lookup_hit;
  logic [DATA_W-1:0] lookup_data;
`endif

  int checks = 0;
  int failures = 0;

  logic [E_W-1:0] exp_q[$];
  int             m_cnt = 0;
  bit             m_write = 1'b0;

  reg_writeback_unit #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .Wen(Wen), .Rd_addr(Rd_addr), .write_data(write_data),
    .busy_mask(busy_mask), .fifo_count(fifo_count),
`ifdef WB_BYPASS_EN
    .lookup_addr(lookup_addr), .lookup_hit(lookup_hit), .lookup_data(lookup_data),
`endif
    .state_dbg(state_dbg)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: advances on each rising edge from the inputs driven before it.
  task automatic model_update();
    int  l;
    int  pushes;
    bit  pop;
    if (!rst_n) begin
      m_cnt = 0; m_write = 1'b0; exp_q.delete();
      return;
    end
    l = (ld_valid && ld_rd != 0) ? 1 : 0;
    pushes = 0;
    if (ld_valid && (m_cnt < DEPTH) && ld_rd != 0) begin
      exp_q.push_back({ld_rd, ld_data}); pushes++;
    end
    if (alu_valid && (m_cnt + l < DEPTH) && alu_rd != 0) begin
      exp_q.push_back({alu_rd, alu_data}); pushes++;
    end
    pop = !m_write && (m_cnt > 0);
    m_cnt = m_cnt + pushes - (pop ? 1 : 0);
    m_write = pop;
  endtask

  // Scoreboard: compare outputs mid-cycle against the model and the expected queue.
  task automatic sample_checks();
    logic [31:0]    exp_busy;
    logic [E_W-1:0] e;
    int             l;
    if (!rst_n) return;
    exp_busy = '0;
    foreach (exp_q[i]) begin
      e = exp_q[i];
      exp_busy[e[DATA_W +: ADDR_W]] = 1'b1;
    end
    exp_busy[0] = 1'b0;
    l = (ld_valid && ld_rd != 0) ? 1 : 0;
    check("fifo_count", 64'(fifo_count), 64'(m_cnt));
    check("wen", 64'(Wen), 64'(m_write));
    check("state", 64'(state_dbg), 64'(m_write));
    check("ld_ready", 64'(ld_ready), 64'(m_cnt < DEPTH));
    check("alu_ready", 64'(alu_ready), 64'((m_cnt + l) < DEPTH));
    check("busy_mask", 64'(busy_mask), 64'(exp_busy));
`ifdef WB_BYPASS_EN
    begin
      bit             hit;
      logic [DATA_W-1:0] d;
      hit = 1'b0; d = '0;
      if (lookup_addr != 0) begin
        for (int i = exp_q.size() - 1; i >= 0 && !hit; i--) begin
          e = exp_q[i];
          if (e[DATA_W +: ADDR_W] == lookup_addr) begin hit = 1'b1; d = e[DATA_W-1:0]; end
        end
      end
      check("lookup_hit", 64'(lookup_hit), 64'(hit));
      if (hit) check("lookup_data", lookup_data, d);
    end
`endif
    if (Wen) begin
      if (exp_q.size() == 0) check("spurious_wen", 64'(Wen), 64'(0));
      else begin
        e = exp_q.pop_front();
        check("rd_addr", 64'(Rd_addr), 64'(e[DATA_W +: ADDR_W]));
        check("write_data", write_data, e[DATA_W-1:0]);
      end
    end
  endtask

  task automatic step();
    @(negedge clk); sample_checks();
    @(posedge clk); model_update();
    #1;
  endtask

  // Driver: present one beat for one edge, then drop valids.
  task automatic drive(input bit lv, input logic [ADDR_W-1:0] lr, input logic [DATA_W-1:0] ldd,
                       input bit av, input logic [ADDR_W-1:0] ar, input logic [DATA_W-1:0] ad);
    ld_valid = lv; ld_rd = lr; ld_data = ldd;
    alu_valid = av; alu_rd = ar; alu_data = ad;
    step();
    ld_valid = 1'b0; alu_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic drain();
    int budget;
    budget = 0;
    while ((exp_q.size() != 0 || m_write) && budget < 50) begin step(); budget++; end
    check("drain_timeout", 64'(exp_q.size()), 64'(0));
    idle(2);
  endtask

  initial begin
    // Reset and reset-value checks
    rst_n = 1'b0;
    model_update();
    repeat (2) @(posedge clk);
    #1;
    check("rst_wen", 64'(Wen), 64'(0));
    check("rst_rd_addr", 64'(Rd_addr), 64'(0));
    check("rst_write_data", write_data, 64'(0));
    check("rst_fifo_count", 64'(fifo_count), 64'(0));
    check("rst_busy", 64'(busy_mask), 64'(0));
    rst_n = 1'b1;
    idle(2);

    // Single ALU push: strobe appears after the second edge.
    drive(0, 0, 0, 1, 5'd10, 64'hFFF);
    check("lat_wen_lo", 64'(Wen), 64'(0));
    check("lat_busy10", 64'(busy_mask), 64'(32'h400));
    step();
    check("lat_wen_hi", 64'(Wen), 64'(1));
    check("lat_rd", 64'(Rd_addr), 64'(10));
    step();
    check("lat_wen_fall", 64'(Wen), 64'(0));
    check("lat_busy_clr", 64'(busy_mask), 64'(0));
    drain();

    // Simultaneous load and ALU pushes: load written first.
    drive(1, 5'd20, 64'h456701023D2, 1, 5'd21, 64'h012005C2);
    drain();

    // Fill with both sources every cycle until credit runs out.
    drive(1, 5'd1, 64'h11, 1, 5'd2, 64'h22);
    drive(1, 5'd3, 64'h33, 1, 5'd4, 64'h44);
    drive(1, 5'd5, 64'h55, 1, 5'd6, 64'h66);
    check("full_count", 64'(fifo_count), 64'(DEPTH));
    check("full_ld_ready", 64'(ld_ready), 64'(0));
    drain();

    // Load to x0: handshake only.
    drive(1, 5'd0, 64'h1234, 0, 0, 0);
    check("x0_count", 64'(fifo_count), 64'(0));
    check("x0_busy", 64'(busy_mask), 64'(0));
    idle(3);

    // Reset during WRITE with two entries queued.
    drive(1, 5'd3, 64'hA3, 1, 5'd4, 64'hA4);
    drive(1, 5'd6, 64'hA6, 0, 0, 0);
    check("pre_rst_wen", 64'(Wen), 64'(1));
    check("pre_rst_count", 64'(fifo_count), 64'(2));
    rst_n = 1'b0;
    model_update();
    #1;
    check("async_wen", 64'(Wen), 64'(0));
    check("async_count", 64'(fifo_count), 64'(0));
    check("async_busy", 64'(busy_mask), 64'(0));
    idle(2);
    rst_n = 1'b1;
    idle(4);

`ifdef WB_BYPASS_EN
    // Two writes to the same register: youngest data wins.
    drive(1, 5'd7, 64'hA, 0, 0, 0);
    lookup_addr = 5'd7;
    drive(0, 0, 0, 1, 5'd7, 64'hB);
    check("byp_hit", 64'(lookup_hit), 64'(1));
    check("byp_data", lookup_data, 64'hB);
    drain();
    check("byp_after", 64'(lookup_hit), 64'(0));
`endif

    // Random traffic
    for (int i = 0; i < 300; i++) begin
`ifdef WB_BYPASS_EN
      lookup_addr = ADDR_W'($urandom_range(0, 31));
`endif
      drive(1'($urandom_range(0, 1)), ADDR_W'($urandom_range(0, 31)), {$urandom, $urandom},
            1'($urandom_range(0, 1)), ADDR_W'($urandom_range(0, 31)), {$urandom, $urandom});
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/reg_writeback_unit.md
# reg_writeback_unit

Writeback-side initiator for the 32 x 64-bit integer register file. Accepts destination/result pairs from the ALU and the load unit through valid/ready handshakes. Queues them in a small FIFO and drives the register file write port (`Wen`, `Rd_addr`, `write_data`) as isolated one-cycle strobes. Publishes a pending-destination mask for hazard detection.

## Interface
Parameters:
- `DATA_W`, 64, result width.
- `ADDR_W`, 5, register address width (32 registers).
- `DEPTH`, 4, FIFO entries; must be a power of two, at least 2.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `ld_valid`  in  1  load result valid.
- `ld_ready`  out  1  load result accepted this cycle.
- `ld_rd`  in  ADDR_W  load destination register.
- `ld_data`  in  DATA_W  load result.
- `alu_valid`  in  1  ALU result valid.
- `alu_ready`  out  1  ALU result accepted this cycle.
- `alu_rd`  in  ADDR_W  ALU destination register.
- `alu_data`  in  DATA_W  ALU result.
- `Wen`  out  1  register file write strobe (registered).
- `Rd_addr`  out  ADDR_W  register file write address (registered).
- `write_data`  out  DATA_W  register file write data (registered).
- `busy_mask`  out  32  bit r set while a write to register r is queued or in flight.
- `fifo_count`  out  $clog2(DEPTH)+1  occupied entries.
- `lookup_addr`  in  ADDR_W  bypass query register; present only with the bypass feature.
- `lookup_hit`  out  1  bypass query hit; present only with the bypass feature.
- `lookup_data`  out  DATA_W  bypass query data; present only with the bypass feature.

## Operation
- Handshake completes on a rising edge where valid and ready are both high.
- Credit is computed from pre-edge `fifo_count` only; a same-cycle pop gives no credit back.
  - `ld_ready` = `fifo_count` < DEPTH.
  - `alu_ready` = `fifo_count` + L < DEPTH, where L = 1 if `ld_valid` and `ld_rd` != 0, else 0.
- Writes to x0: the handshake completes under the normal ready rules, but no entry is enqueued, no credit is consumed, and x0 is never written.
- Both sources accepted on the same edge: the load entry is enqueued ahead of the ALU entry.
- The FSM has two states.
  - IDLE to WRITE: taken on an edge where state is IDLE and `fifo_count` > 0. The head entry is popped into `Rd_addr`/`write_data` and `Wen` is set to 1.
  - WRITE to IDLE: always taken on the next edge. `Wen` is set to 0; `Rd_addr` and `write_data` hold their values.
- `Wen` is high for exactly one cycle and always low for at least one cycle afterwards. This gives a clean rising edge per write and a maximum rate of one write per two cycles.
- `busy_mask` is combinational: the OR of one-hot(rd) over valid FIFO entries, plus `Rd_addr` while in WRITE. Bit 0 is always 0.
- Push and pop on the same edge: `fifo_count` changes by pushes minus 1. Pointers wrap modulo DEPTH.

## Timing
- Reset values: `Wen`=0, `Rd_addr`=0, `write_data`=0, `fifo_count`=0, `busy_mask`=0, state=IDLE, pointers=0.
- Reset assertion mid-operation: all queued entries are discarded and `Wen` drops immediately, without waiting for a clock edge.
- Latency: an entry pushed at edge N into an empty FIFO, with state IDLE, gives `Wen`=1 during the cycle after edge N+1.
- Throughput: one write per 2 cycles.
- Ready outputs depend combinationally on `ld_valid`/`ld_rd`. Valid/rd/data inputs must be stable before the rising edge.

## Configuration
- `WB_BYPASS_EN` defined: the `lookup_*` ports exist.
  - `lookup_hit`=1 when `lookup_addr` != 0 and matches a valid queued or in-flight entry.
  - `lookup_data` is the youngest matching entry's data. Precedence: newest FIFO entry first, then the in-flight entry.
  - The lookup is combinational.
- `WB_BYPASS_EN` undefined: the `lookup_*` ports are absent and no comparison logic is built.

## Test plan
- Reset, then a single ALU push (rd=10, data=0xFFF): `Wen` pulses for 1 cycle, 2 cycles after the push edge, with `Rd_addr`=10 and `write_data`=0xFFF. `busy_mask` bit 10 is set from after the push until `Wen` falls.
- Simultaneous ld (rd=20, 0x456701023D2) and alu (rd=21, 0x012005C2) pushes into an empty FIFO: `Wen` pulses at cycles +2 and +4 after the push edge; rd=20 is written first, then rd=21.
- Push 4 entries back-to-back with no drain credit: `fifo_count`=4 and `ld_ready`=0. With `fifo_count`=3 and `ld_valid` set to rd=5: `alu_ready`=0. After a pop, `ld_ready` returns to 1.
- Load with rd=0 and data=0x1234: `ld_ready`=1, `fifo_count` unchanged, no `Wen` pulse, `busy_mask` stays 0.
- Deassert `rst_n` while in WRITE with 2 entries queued: `Wen`, `fifo_count` and `busy_mask` all go to 0 without a clock edge. No writes occur after reset release.
- With `WB_BYPASS_EN`, queue rd=7/0xA then rd=7/0xB and set `lookup_addr`=7: `lookup_hit`=1 and `lookup_data`=0xB. After both writes drain, `lookup_hit`=0.
